spu_result_uart_tx: RTL
=======================

Name: spu_result_uart_tx

Overview:
Result-side transmitter for the spatial processing unit. It takes 8-bit result bytes from the SPU datapath over a valid/ready handshake and buffers them in a 4-entry FIFO. It then serialises each byte onto a single output pin as 8N1 UART frames (start bit, 8 data bits LSB first, stop bit). It sits between the SPU sum/result register and a spare uio pin, so results can stream off-chip to a host.

Parameters:
CLK_DIV, 434, clock cycles per UART bit (434 gives ~115200 baud at 50 MHz); legal range 2..65535
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW = 4 entries

Ports:
clk  input  1  system clock (50 MHz nominal)
rst_n  input  1  asynchronous active-low reset
ena  input  1  block enable; 0 blocks acceptance and new frame starts
res_data  input  8  result byte to transmit
res_valid  input  1  res_data is valid this cycle
res_ready  output  1  block can accept a byte this cycle
tx  output  1  UART serial output, idle high
busy  output  1  frame in progress or FIFO non-empty
fifo_count  output  FIFO_AW+1  number of bytes currently buffered

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is asynchronous and active-low on rst_n; deassertion is taken synchronously at the next clk edge.
  - While rst_n=0: tx=1, busy=0, fifo_count=0, res_ready=0; FIFO pointers, baud counter, bit counter and shift register are cleared; FSM is in IDLE.
- Input handshake:
  - res_ready = ena & (fifo_count < 2**FIFO_AW). It is computed from registered state only and never depends on res_valid.
  - A byte is accepted on an edge where res_valid & res_ready. It is written at the write pointer; the pointer wraps modulo depth.
  - When res_ready=0 the byte is not taken. The producer holds it; data is never dropped.
- Push/pop in the same cycle:
  - fifo_count is unchanged.
  - When full, a pop does not make res_ready high in that same cycle; ready rises the cycle after the pop.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If ena=1 and fifo_count>0: pop the head byte into the shift register, load the baud counter with CLK_DIV-1, and go to START.
- START:
  - tx=0 for CLK_DIV cycles.
  - When the baud counter reaches 0: go to DATA with bit index 0, and reload the counter.
- DATA:
  - tx = shift_reg[0]. Each bit is held CLK_DIV cycles, then the register shifts right and the bit index increments.
  - After bit index 7 completes, go to STOP.
- STOP:
  - tx=1 for CLK_DIV cycles.
  - At the final cycle: if ena=1 and FIFO non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Frame timing:
  - tx is a registered output.
  - For a byte accepted into an empty FIFO while idle: the pop occurs at the next edge, and tx falls on the edge after that.
  - One frame occupies exactly 10*CLK_DIV cycles.
- ena=0 mid-frame: the current frame completes normally, then the FSM holds in IDLE. Buffered bytes are retained.
- busy = (state != IDLE) | (fifo_count != 0).
- Reset mid-frame: tx returns to 1 immediately (asynchronously). All buffered bytes are discarded; no partial frame resumes.

Test Plan:
- Reset: assert rst_n=0 with res_valid=1, res_data=0xFF -> tx=1, busy=0, fifo_count=0, res_ready=0. After release with ena=1: res_ready=1 on the next cycle.
- Single byte, CLK_DIV=4: push 0xA5 while idle.
  - tx falls 2 edges after acceptance.
  - Bit sequence, each bit 4 cycles, 40 cycles total: 0, 1,0,1,0,0,1,0,1, 1.
  - busy drops right after the stop bit.
- Burst, CLK_DIV=4: hold res_valid=1 with bytes 0x01..0x06.
  - 0x01..0x05 are accepted back-to-back; fifo_count goes 1,1,2,3,4.
  - res_ready stays low until 0x02 is popped at the end of frame 1, then 0x06 is accepted.
  - Six frames are sent with no idle gap, in order 0x01..0x06.
- Enable gating, CLK_DIV=4: push 0x3C and 0xC3, then drop ena mid-frame of 0x3C.
  - 0x3C completes; tx stays 1; fifo_count stays 1; res_ready=0.
  - Raise ena -> 0xC3 transmits.
- Reset mid-frame: pulse rst_n low during DATA bit 3 with 2 bytes buffered.
  - tx=1 immediately and fifo_count=0.
  - No further frames start after release until new bytes are pushed.
- Default CLK_DIV=434: one byte 0x55 -> each bit measured as exactly 434 cycles, frame = 4340 cycles.

Source files
------------

// File: rtl/spu_result_uart_tx.sv
// Result-byte UART transmitter: a small FIFO feeds an 8N1 serialiser.
// tx is a registered copy of the FSM bit level, so it trails the state by one cycle.
module spu_result_uart_tx #(
  parameter int CLK_DIV = 434,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [7:0]         res_data,
  input  logic               res_valid,
  output logic               res_ready,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [15:0]        baud;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               run;
  logic               push, pop, bit_end, can_pop;

  // run holds res_ready low through reset and for the first edge after release
  assign res_ready = ena & run & (fifo_count < FULL);
  assign push      = res_valid & res_ready;
  assign bit_end   = (baud == 16'd0);
  assign can_pop   = ena & (fifo_count != '0);
  assign pop       = can_pop & ((state == IDLE) | ((state == STOP) & bit_end));
  assign busy      = (state != IDLE) | (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= res_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      run     <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg <= mem[rptr];
            baud  <= BAUD_MAX;
            state <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            baud    <= BAUD_MAX;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        DATA: begin
          tx <= shreg[0];
          if (bit_end) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
            baud    <= BAUD_MAX;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            // back-to-back frames: reload straight into START with no idle bit
            if (pop) begin
              shreg <= mem[rptr];
              baud  <= BAUD_MAX;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
